// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite scheduler: scans the slot table during horizontal blanking and
// publishes a registered list of up to MAXLINE sprites for the next visible line.
module sprite_line_scheduler #(
  parameter int unsigned NSPR      = 8,
  parameter int unsigned MAXLINE   = 4,
  parameter int unsigned HALF_W    = 15,
  parameter int unsigned HALF_H    = 25,
  parameter int unsigned H_SCAN    = 640,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_TOTAL   = 525,
  localparam int unsigned IW       = $clog2(NSPR)
) (
  input  logic                    clk_25m,
  input  logic                    rst,
  input  logic [9:0]              hc,
  input  logic [9:0]              vc,
  input  logic                    wr_en,
  input  logic [IW-1:0]           wr_idx,
  input  logic [9:0]              wr_x,
  input  logic [9:0]              wr_y,
  input  logic                    wr_exist,
  output logic                    wr_ready,
  output logic [MAXLINE-1:0]      act_valid,
  output logic [MAXLINE*IW-1:0]   act_id,
  output logic [MAXLINE*10-1:0]   act_x,
  output logic [MAXLINE*6-1:0]    act_row,
  output logic                    line_ovf,
  output logic                    frame_ovf
);

  localparam int unsigned CW = $clog2(MAXLINE + 1);

  // Rows are reported in 6 bits, so a sprite may be at most 64 lines tall.
  if (NSPR < 2 || NSPR > 16 || (NSPR & (NSPR - 1)) != 0 || MAXLINE < 1 || HALF_W < 1 ||
      HALF_H < 1 || 2 * HALF_H > 64) begin : g_param_check
    $error("sprite_line_scheduler: unsupported parameter set");
  end

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e state_q, state_d;

  // Sprite table
  logic [9:0]      slot_x_q     [NSPR];
  logic [9:0]      slot_y_q     [NSPR];
  logic [NSPR-1:0] slot_exist_q;

  // Scan context and shadow list
  logic [9:0]      tl_q;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   sh_id_q  [MAXLINE];
  logic [9:0]      sh_x_q   [MAXLINE];
  logic [5:0]      sh_row_q [MAXLINE];
  logic [CW-1:0]   sh_cnt_q;
  logic            sh_ovf_q;

  // Published list
  logic [MAXLINE-1:0]    act_valid_q;
  logic [MAXLINE*IW-1:0] act_id_q;
  logic [MAXLINE*10-1:0] act_x_q;
  logic [MAXLINE*6-1:0]  act_row_q;
  logic                  line_ovf_q;
  logic                  frame_ovf_q;

  logic        scan_trig;
  logic [9:0]  tl_next;
  logic [10:0] tl_ext;
  logic [10:0] y_ext;
  logic        tl_visible;
  logic        hit;
  logic [5:0]  row;
  logic        list_full;

  assign scan_trig  = (hc == 10'(H_SCAN));
  assign tl_next    = (vc == 10'(V_TOTAL - 1)) ? 10'd0 : vc + 10'd1;
  assign tl_ext     = {1'b0, tl_q};
  assign y_ext      = {1'b0, slot_y_q[idx_q]};
  assign tl_visible = (tl_q < 10'(V_VISIBLE));
  // Compare as tl+HALF_H >= y rather than tl >= y-HALF_H so that y < HALF_H cannot underflow.
  assign hit        = tl_visible && slot_exist_q[idx_q] &&
                      (tl_ext + 11'(HALF_H) >= y_ext) && (tl_ext < y_ext + 11'(HALF_H));
  assign row        = 6'(tl_ext + 11'(HALF_H) - y_ext);
  assign list_full  = (sh_cnt_q == CW'(MAXLINE));

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    unique case (state_q)
      StIdle: begin
        wr_ready = 1'b1;
        if (scan_trig) state_d = StScan;
      end
      StScan: begin
        if (idx_q == IW'(NSPR - 1)) state_d = StCommit;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // The table only accepts writes while idle, so a scan always sees a stable snapshot.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      for (int unsigned s = 0; s < NSPR; s++) begin
        slot_x_q[s] <= '0;
        slot_y_q[s] <= '0;
      end
      slot_exist_q <= '0;
    end else if (state_q == StIdle && wr_en) begin
      slot_x_q[wr_idx]     <= wr_x;
      slot_y_q[wr_idx]     <= wr_y;
      slot_exist_q[wr_idx] <= wr_exist;
    end
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      tl_q        <= '0;
      idx_q       <= '0;
      sh_cnt_q    <= '0;
      sh_ovf_q    <= 1'b0;
      for (int unsigned e = 0; e < MAXLINE; e++) begin
        sh_id_q[e]  <= '0;
        sh_x_q[e]   <= '0;
        sh_row_q[e] <= '0;
      end
      act_valid_q <= '0;
      act_id_q    <= '0;
      act_x_q     <= '0;
      act_row_q   <= '0;
      line_ovf_q  <= 1'b0;
      frame_ovf_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (scan_trig) begin
            tl_q     <= tl_next;
            idx_q    <= '0;
            sh_cnt_q <= '0;
            sh_ovf_q <= 1'b0;
            for (int unsigned e = 0; e < MAXLINE; e++) begin
              sh_id_q[e]  <= '0;
              sh_x_q[e]   <= '0;
              sh_row_q[e] <= '0;
            end
          end
        end
        StScan: begin
          idx_q <= idx_q + IW'(1);
          if (hit) begin
            if (list_full) begin
              sh_ovf_q <= 1'b1;
            end else begin
              for (int unsigned e = 0; e < MAXLINE; e++) begin
                if (sh_cnt_q == CW'(e)) begin
                  sh_id_q[e]  <= idx_q;
                  sh_x_q[e]   <= slot_x_q[idx_q];
                  sh_row_q[e] <= row;
                end
              end
              sh_cnt_q <= sh_cnt_q + CW'(1);
            end
          end
        end
        StCommit: begin
          for (int unsigned e = 0; e < MAXLINE; e++) begin
            act_valid_q[e]         <= (CW'(e) < sh_cnt_q);
            act_id_q[e*IW +: IW]   <= sh_id_q[e];
            act_x_q[e*10 +: 10]    <= sh_x_q[e];
            act_row_q[e*6 +: 6]    <= sh_row_q[e];
          end
          line_ovf_q  <= sh_ovf_q;
          // Line 0 opens a new frame, so the sticky flag restarts there.
          frame_ovf_q <= (tl_q == 10'd0) ? sh_ovf_q : (frame_ovf_q | sh_ovf_q);
        end
        default: ;
      endcase
    end
  end

  assign act_valid = act_valid_q;
  assign act_id    = act_id_q;
  assign act_x     = act_x_q;
  assign act_row   = act_row_q;
  assign line_ovf  = line_ovf_q;
  assign frame_ovf = frame_ovf_q;

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: directed cases plus randomized slot tables checked
// against a list-building reference model.
module tb_sprite_line_scheduler;

  logic        clk_25m;
  logic        rst;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic [9:0]  wr_x;
  logic [9:0]  wr_y;
  logic        wr_exist;
  logic        wr_ready;
  logic [3:0]  act_valid;
  logic [11:0] act_id;
  logic [39:0] act_x;
  logic [23:0] act_row;
  logic        line_ovf;
  logic        frame_ovf;

  sprite_line_scheduler dut (
    .clk_25m   (clk_25m),
    .rst       (rst),
    .hc        (hc),
    .vc        (vc),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_exist  (wr_exist),
    .wr_ready  (wr_ready),
    .act_valid (act_valid),
    .act_id    (act_id),
    .act_x     (act_x),
    .act_row   (act_row),
    .line_ovf  (line_ovf),
    .frame_ovf (frame_ovf)
  );

  initial clk_25m = 1'b0;
  always #20 clk_25m = ~clk_25m;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference slot table and expected published state
  logic [9:0]  m_x [8];
  logic [9:0]  m_y [8];
  bit          m_ex [8];
  logic [3:0]  e_valid;
  logic [11:0] e_id;
  logic [39:0] e_x;
  logic [23:0] e_row;
  logic        e_lovf;
  logic        e_fovf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) begin
      m_x[s] = '0; m_y[s] = '0; m_ex[s] = 0;
    end
    e_valid = '0; e_id = '0; e_x = '0; e_row = '0; e_lovf = 0; e_fovf = 0;
  endtask

  task automatic model_scan(input int v);
    int tl, n, y;
    tl = (v == 524) ? 0 : v + 1;
    n = 0;
    e_valid = '0; e_id = '0; e_x = '0; e_row = '0; e_lovf = 0;
    if (tl < 480) begin
      for (int s = 0; s < 8; s++) begin
        y = int'(m_y[s]);
        if (m_ex[s] && (tl + 25 >= y) && (tl < y + 25)) begin
          if (n < 4) begin
            e_valid[n]       = 1'b1;
            e_id[n*3 +: 3]   = 3'(s);
            e_x[n*10 +: 10]  = m_x[s];
            e_row[n*6 +: 6]  = 6'((tl + 25 - y) % 64);
            n++;
          end else begin
            e_lovf = 1'b1;
          end
        end
      end
    end
    e_fovf = (tl == 0) ? e_lovf : (e_fovf | e_lovf);
  endtask

  task automatic compare_outputs(input string pfx);
    check_eq({pfx, "_valid"}, 64'(act_valid), 64'(e_valid));
    check_eq({pfx, "_id"},    64'(act_id),    64'(e_id));
    check_eq({pfx, "_x"},     64'(act_x),     64'(e_x));
    check_eq({pfx, "_row"},   64'(act_row),   64'(e_row));
    check_eq({pfx, "_lovf"},  64'(line_ovf),  64'(e_lovf));
    check_eq({pfx, "_fovf"},  64'(frame_ovf), 64'(e_fovf));
  endtask

  task automatic write_slot(input int i, input int x, input int y, input bit e);
    @(negedge clk_25m);
    hc = 10'd660;
    check_eq("wr_ready_idle", 64'(wr_ready), 64'd1);
    wr_en = 1'b1; wr_idx = 3'(i); wr_x = 10'(x); wr_y = 10'(y); wr_exist = e;
    @(negedge clk_25m);
    wr_en = 1'b0;
    m_x[i] = 10'(x); m_y[i] = 10'(y); m_ex[i] = e;
  endtask

  // Walks hc across the blanking trigger on line v; optionally injects a write or a reset
  // while the scan is in progress.
  task automatic do_scan(input int v, input bit mid_write, input bit mid_rst);
    logic [3:0]  p_valid;
    logic [39:0] p_x;
    p_valid = e_valid;
    p_x     = e_x;
    vc = 10'(v);
    for (int h = 636; h <= 652; h++) begin
      @(negedge clk_25m);
      if (h == 649 && !mid_rst) begin
        check_eq("hold_valid", 64'(act_valid), 64'(p_valid));
        check_eq("hold_x",     64'(act_x),     64'(p_x));
      end
      if (mid_write && h == 645) begin
        check_eq("wr_ready_scan", 64'(wr_ready), 64'd0);
        wr_en = 1'b1; wr_idx = 3'd3; wr_x = 10'd300; wr_y = 10'd100; wr_exist = 1'b1;
      end
      if (mid_write && h == 646) wr_en = 1'b0;
      if (mid_rst && h == 645) begin
        model_clear();
        check_eq("rst_wr_ready", 64'(wr_ready), 64'd1);
        compare_outputs("rst_mid");
        rst = 1'b0;
      end
      hc = 10'(h);
      if (mid_rst && h == 644) rst = 1'b1;
    end
    @(negedge clk_25m);
    if (!mid_rst) model_scan(v);
    compare_outputs("scan");
  endtask

  initial begin
    int nw, v, r, tl, yy;
    rst = 1'b1; hc = 10'd0; vc = 10'd0;
    wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_exist = 1'b0;
    model_clear();
    repeat (3) @(negedge clk_25m);
    rst = 1'b0;
    @(negedge clk_25m);
    check_eq("reset_wr_ready", 64'(wr_ready), 64'd1);
    compare_outputs("reset");

    // Single sprite, row inside it
    write_slot(2, 100, 100, 1);
    do_scan(79, 0, 0);
    check_eq("t1_valid", 64'(act_valid), 64'h1);
    check_eq("t1_id0",   64'(act_id[2:0]), 64'd2);
    check_eq("t1_row0",  64'(act_row[5:0]), 64'd5);
    check_eq("t1_x0",    64'(act_x[9:0]), 64'd100);

    // Top edge at line 0, and a sprite whose top lies above the screen
    write_slot(0, 40, 25, 1);
    do_scan(524, 0, 0);
    check_eq("t2_row_top", 64'(act_row[5:0]), 64'd0);
    write_slot(0, 40, 10, 1);
    do_scan(524, 0, 0);
    check_eq("t2_row_noufl", 64'(act_row[5:0]), 64'd15);

    // Overflow, sticky frame flag, frame restart
    for (int i = 0; i < 6; i++) write_slot(i, 50 + i * 10, 200, 1);
    do_scan(199, 0, 0);
    check_eq("t3_valid", 64'(act_valid), 64'hf);
    check_eq("t3_ids",   64'(act_id), 64'h688);
    check_eq("t3_lovf",  64'(line_ovf), 64'd1);
    check_eq("t3_fovf",  64'(frame_ovf), 64'd1);
    do_scan(150, 0, 0);
    check_eq("t3_fovf_sticky", 64'(frame_ovf), 64'd1);
    for (int i = 0; i < 6; i++) write_slot(i, 0, 200, 0);
    do_scan(524, 0, 0);
    check_eq("t3_fovf_clear", 64'(frame_ovf), 64'd0);

    // A write during a scan is dropped; the same write while idle lands
    do_scan(99, 1, 0);
    check_eq("t4_lost", 64'(act_valid), 64'h0);
    write_slot(3, 300, 100, 1);
    do_scan(99, 0, 0);
    check_eq("t4_valid", 64'(act_valid), 64'h1);
    check_eq("t4_row0",  64'(act_row[5:0]), 64'd25);

    // Reset in the middle of a scan
    for (int i = 0; i < 6; i++) write_slot(i, 50 + i * 10, 200, 1);
    do_scan(199, 0, 0);
    do_scan(199, 0, 1);
    do_scan(199, 0, 0);
    check_eq("t5_empty", 64'(act_valid), 64'h0);

    // Target line past the visible area commits an empty list
    write_slot(1, 77, 480, 1);
    do_scan(479, 0, 0);
    check_eq("t6_empty", 64'(act_valid), 64'h0);
    do_scan(478, 0, 0);
    check_eq("t6_last_line", 64'(act_valid), 64'h1);

    // Randomized tables
    for (int it = 0; it < 60; it++) begin
      v = int'($urandom_range(0, 524));
      r = int'($urandom_range(0, 9));
      if (r == 0) v = 524;
      if (r == 1) v = 479;
      tl = (v == 524) ? 0 : v + 1;
      nw = int'($urandom_range(0, 4));
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          yy = tl + int'($urandom_range(0, 52)) - 26;
          if (yy < 0) yy = int'($urandom_range(0, 30));
        end else begin
          yy = int'($urandom_range(0, 1023));
        end
        write_slot(int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)), yy,
                   $urandom_range(0, 4) != 0);
      end
      do_scan(v, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
